// File: rtl/ber_pkg.sv
// Shared state codes, default parameters and width helper for the PRBS
// bit-error-rate phase checker.
package ber_pkg;

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam int unsigned DEF_DEPTH    = 1024;
  localparam int unsigned DEF_WIN      = 511;
  localparam int unsigned DEF_LOCK_THR = 0;
  localparam int unsigned DEF_LOSS_THR = 64;
  localparam int unsigned DEF_CNT_W    = 64;

  function automatic int unsigned ptrWidth(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ber_delay_line.sv
// Reference PRBS delay line: tap p is the reference delayed by p valid
// samples, tap 0 being the live input bit.
module ber_delay_line #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic                     i_shift,
  input  logic                     i_bit,
  input  logic [$clog2(DEPTH)-1:0] i_sel,
  output logic                     o_tap
);

  logic [DEPTH-2:0] history;
  logic [DEPTH-1:0] taps;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      history <= '0;
    end else if (i_shift) begin
      history <= {history[DEPTH-3:0], i_bit};
    end
  end

  assign taps  = {history, i_bit};
  assign o_tap = taps[i_sel];

endmodule

// File: rtl/ber_phase_checker.sv
// BER checker for one demodulated channel: sweeps reference delays for the
// best alignment, then locks and accumulates bit/error counts.
module ber_phase_checker
  import ber_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned WIN      = DEF_WIN,
  parameter int unsigned LOCK_THR = DEF_LOCK_THR,
  parameter int unsigned LOSS_THR = DEF_LOSS_THR,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic                       i_rx,
  input  logic                       i_ref,
  input  logic                       i_clear,
  output logic                       o_locked,
  output logic [$clog2(DEPTH)-1:0]   o_phase,
  output logic [$clog2(WIN+1)-1:0]   o_min_err,
  output logic                       o_search_fail,
  output logic [CNT_W-1:0]           o_bit_cnt,
  output logic [CNT_W-1:0]           o_err_cnt
);

  localparam int unsigned PW = ptrWidth(DEPTH);
  localparam int unsigned EW = $clog2(WIN + 1);

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] bestTap;
  logic [PW-1:0] bestTapNow;
  logic [PW-1:0] sel;
  logic [EW-1:0] wcnt;
  logic [EW-1:0] werr;
  logic [EW-1:0] best;
  logic [EW-1:0] bestNow;
  logic [EW-1:0] eClose;
  logic          sample;
  logic          tapBit;
  logic          mis;
  logic          winClose;
  logic          improve;

  assign sample = i_valid && i_enable;
  assign sel    = (state == LOCKED) ? o_phase : ptr;

  ber_delay_line #(.DEPTH(DEPTH)) delayLine (
    .clock   (clock),
    .i_reset (i_reset),
    .i_shift (sample),
    .i_bit   (i_ref),
    .i_sel   (sel),
    .o_tap   (tapBit)
  );

  // Window error count including the current sample, and the running best
  // candidate as it would stand if this sample closes the window.
  assign mis        = i_rx ^ tapBit;
  assign winClose   = sample && (wcnt == EW'(WIN - 1));
  assign eClose     = werr + EW'(mis);
  assign improve    = eClose < best;
  assign bestNow    = improve ? eClose : best;
  assign bestTapNow = improve ? ptr : bestTap;
  assign o_locked   = (state == LOCKED);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state         <= SEARCH;
      ptr           <= '0;
      bestTap       <= '0;
      best          <= '1;
      wcnt          <= '0;
      werr          <= '0;
      o_phase       <= '0;
      o_min_err     <= '1;
      o_search_fail <= 1'b0;
      o_bit_cnt     <= '0;
      o_err_cnt     <= '0;
    end else begin
      o_search_fail <= 1'b0;
      if (sample) begin
        if (winClose) begin
          wcnt <= '0;
          werr <= '0;
        end else begin
          wcnt <= wcnt + EW'(1);
          werr <= eClose;
        end
        if (state == LOCKED) begin
          if (o_bit_cnt != '1) o_bit_cnt <= o_bit_cnt + CNT_W'(1);
          if (mis && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + CNT_W'(1);
          if (winClose && (eClose > EW'(LOSS_THR))) begin
            state <= SEARCH;
            ptr   <= '0;
            best  <= '1;
          end
        end else if (winClose) begin
          best    <= bestNow;
          bestTap <= bestTapNow;
          if (eClose == '0) begin
            state     <= LOCKED;
            o_phase   <= ptr;
            o_min_err <= '0;
          end else if (ptr == PW'(DEPTH - 1)) begin
            o_min_err <= bestNow;
            if (bestNow <= EW'(LOCK_THR)) begin
              state   <= LOCKED;
              o_phase <= bestTapNow;
            end else begin
              o_search_fail <= 1'b1;
              ptr           <= '0;
              best          <= '1;
            end
          end else begin
            ptr <= ptr + PW'(1);
          end
        end
      end
      // A clear overrides any count update landing in the same cycle.
      if (i_enable && i_clear) begin
        o_bit_cnt <= '0;
        o_err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ber_phase_checker.sv
// Scoreboard bench for ber_phase_checker: random PRBS-like traffic through a
// delayed channel, compared against a sample-level reference model.
module tb_ber_phase_checker;

  localparam int DEPTH    = 16;
  localparam int WIN      = 31;
  localparam int LOCK_THR = 1;
  localparam int LOSS_THR = 3;
  localparam int CNT_W    = 10;
  localparam int PW       = $clog2(DEPTH);
  localparam int EW       = $clog2(WIN + 1);
  localparam int SAT      = (1 << CNT_W) - 1;
  localparam int MIN_ONES = (1 << EW) - 1;

  logic             clock;
  logic             i_reset;
  logic             i_enable;
  logic             i_valid;
  logic             i_rx;
  logic             i_ref;
  logic             i_clear;
  logic             o_locked;
  logic [PW-1:0]    o_phase;
  logic [EW-1:0]    o_min_err;
  logic             o_search_fail;
  logic [CNT_W-1:0] o_bit_cnt;
  logic [CNT_W-1:0] o_err_cnt;

  ber_phase_checker #(
    .DEPTH(DEPTH), .WIN(WIN), .LOCK_THR(LOCK_THR), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_rx(i_rx), .i_ref(i_ref), .i_clear(i_clear), .o_locked(o_locked),
    .o_phase(o_phase), .o_min_err(o_min_err), .o_search_fail(o_search_fail),
    .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int locked;
    int phase;
    int minErr;
    int fail;
    int bitCnt;
    int errCnt;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: state kept as plain integers; a sweep records every
  // tap's window error count and picks the lowest-index minimum at the end.
  bit   hist[$];
  int   sweepErr[$];
  bit   mLocked;
  int   mPtr, mPhase, mMinErr, mBit, mErr, mWcnt, mWerr;
  bit   mFail;
  int   chanDelay;

  function void modelReset();
    mLocked = 0; mPtr = 0; mPhase = 0; mMinErr = MIN_ONES;
    mBit = 0; mErr = 0; mWcnt = 0; mWerr = 0; mFail = 0;
    sweepErr.delete();
    hist.delete();
    repeat (DEPTH - 1) hist.push_back(1'b0);
  endfunction

  function void modelStep(input bit v, input bit en, input bit rx, input bit refb, input bit clr);
    int sel, e, mn, arg;
    bit tapBit, mis, closing;
    mFail = 0;
    if (!en) return;
    if (v) begin
      sel     = mLocked ? mPhase : mPtr;
      tapBit  = (sel == 0) ? refb : hist[sel-1];
      mis     = rx ^ tapBit;
      e       = mWerr + int'(mis);
      closing = (mWcnt == WIN - 1);
      if (closing) begin mWcnt = 0; mWerr = 0; end
      else begin mWcnt++; mWerr = e; end
      if (mLocked) begin
        if (mBit < SAT) mBit++;
        if (mis && mErr < SAT) mErr++;
        if (closing && e > LOSS_THR) begin
          mLocked = 0; mPtr = 0; sweepErr.delete();
        end
      end else if (closing) begin
        sweepErr.push_back(e);
        if (e == 0) begin
          mLocked = 1; mPhase = mPtr; mMinErr = 0;
        end else if (mPtr == DEPTH - 1) begin
          mn = 1 << EW; arg = 0;
          for (int i = 0; i < sweepErr.size(); i++)
            if (sweepErr[i] < mn) begin mn = sweepErr[i]; arg = i; end
          mMinErr = mn;
          if (mn <= LOCK_THR) begin
            mLocked = 1; mPhase = arg;
          end else begin
            mFail = 1; mPtr = 0; sweepErr.delete();
          end
        end else begin
          mPtr++;
        end
      end
      hist.push_front(refb);
      void'(hist.pop_back());
    end
    if (clr) begin mBit = 0; mErr = 0; end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus, issued on the falling edge; expectation queued.
  task automatic applyStimulus(input bit v, input bit en, input bit err, input bit clr, input bit rst);
    bit   refb, rx;
    exp_t e;
    refb = 1'($urandom_range(0, 1));
    if (v) rx = ((chanDelay == 0) ? refb : hist[chanDelay-1]) ^ err;
    else   rx = 1'($urandom_range(0, 1));
    i_reset = rst; i_enable = en; i_valid = v; i_rx = rx; i_ref = refb; i_clear = clr;
    if (rst) modelReset();
    else     modelStep(v, en, rx, refb, clr);
    e.locked = mLocked; e.phase = mPhase; e.minErr = mMinErr;
    e.fail = mFail; e.bitCnt = mBit; e.errCnt = mErr;
    expQ.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: every registered output update is compared one step after the edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("sbLocked", int'(o_locked), e.locked);
      checkOutput("sbPhase", int'(o_phase), e.phase);
      checkOutput("sbMinErr", int'(o_min_err), e.minErr);
      checkOutput("sbSearchFail", int'(o_search_fail), e.fail);
      checkOutput("sbBitCnt", int'(o_bit_cnt), e.bitCnt);
      checkOutput("sbErrCnt", int'(o_err_cnt), e.errCnt);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fails, locks;
    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_rx = 1'b0; i_ref = 1'b0; i_clear = 1'b0;
    chanDelay = 5;
    modelReset();
    @(negedge clock);

    // Reset state, then clean channel at delay 5 with continuous valid.
    repeat (2) applyStimulus(0, 1, 0, 0, 1);
    checkOutput("resetLocked", int'(o_locked), 0);
    checkOutput("resetPhase", int'(o_phase), 0);
    checkOutput("resetMinErr", int'(o_min_err), MIN_ONES);
    checkOutput("resetBitCnt", int'(o_bit_cnt), 0);
    repeat (6 * WIN - 1) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("lockEarly", int'(o_locked), 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("lockOnTime", int'(o_locked), 1);
    checkOutput("lockPhase5", int'(o_phase), 5);
    checkOutput("lockMinErr0", int'(o_min_err), 0);

    // Same channel with valid toggling: only valid samples count.
    applyStimulus(0, 1, 0, 0, 1);
    for (int k = 0; k < 370; k++) applyStimulus(k % 2 == 0, 1, 0, 0, 0);
    checkOutput("toggleEarly", int'(o_locked), 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("toggleLocked", int'(o_locked), 1);
    checkOutput("togglePhase", int'(o_phase), 5);
    for (int k = 371; k < 381; k++) applyStimulus(k % 2 == 0, 1, 0, 0, 0);
    checkOutput("toggleBitCnt", int'(o_bit_cnt), 5);

    // Error burst of 10 inside one locked window drops lock; relock at 5.
    repeat (100) applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < WIN && mWcnt != 5; k++) applyStimulus(1, 1, 0, 0, 0);
    repeat (10) applyStimulus(1, 1, 1, 0, 0);
    for (int k = 0; k < 2 * WIN && mLocked; k++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("lossUnlocked", int'(o_locked), 0);
    checkOutput("lossErrHeld", int'(o_err_cnt), 10);
    for (int k = 0; k < DEPTH * WIN + 4 && !mLocked; k++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("relocked", int'(o_locked), 1);
    checkOutput("relockPhase", int'(o_phase), 5);

    // Clear coinciding with a valid error sample.
    repeat (1000) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("clearBitCnt", int'(o_bit_cnt), 0);
    checkOutput("clearErrCnt", int'(o_err_cnt), 0);

    // Delay 9 with one error per window: full sweep, lock on the minimum.
    chanDelay = 9;
    applyStimulus(0, 1, 0, 0, 1);
    repeat (DEPTH * WIN - 1) applyStimulus(1, 1, mWcnt == 0, 0, 0);
    checkOutput("sweepEarly", int'(o_locked), 0);
    applyStimulus(1, 1, mWcnt == 0, 0, 0);
    checkOutput("sweepLocked", int'(o_locked), 1);
    checkOutput("sweepPhase9", int'(o_phase), 9);
    checkOutput("sweepMinErr1", int'(o_min_err), 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("midLockRstLocked", int'(o_locked), 0);
    checkOutput("midLockRstPhase", int'(o_phase), 0);
    checkOutput("midLockRstMinErr", int'(o_min_err), MIN_ONES);

    // Two errors per window exceeds the lock threshold on every sweep.
    fails = 0; locks = 0;
    repeat (2 * DEPTH * WIN + 3) begin
      applyStimulus(1, 1, mWcnt < 2, 0, 0);
      if (o_search_fail) fails++;
      if (o_locked) locks++;
    end
    checkOutput("failPulses", fails, 2);
    checkOutput("failNeverLocked", locks, 0);
    checkOutput("failMinErr2", int'(o_min_err), 2);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("midSearchRstMinErr", int'(o_min_err), MIN_ONES);
    checkOutput("midSearchRstPhase", int'(o_phase), 0);

    // Saturation: three errors per window keeps lock while counts top out.
    chanDelay = 3;
    for (int k = 0; k < DEPTH * WIN && !mLocked; k++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("satLocked", int'(o_locked), 1);
    repeat (360 * WIN) applyStimulus(1, 1, mWcnt < 3, 0, 0);
    checkOutput("satErrCnt", int'(o_err_cnt), SAT);
    checkOutput("satBitCnt", int'(o_bit_cnt), SAT);
    checkOutput("satStillLocked", int'(o_locked), 1);

    // Randomized traffic: delays, valid gaps, enable drops, clears, resets.
    for (int it = 0; it < 4; it++) begin
      chanDelay = $urandom_range(0, DEPTH - 1);
      applyStimulus(0, 1, 0, 0, 1);
      repeat (1500)
        applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) != 0,
                      $urandom_range(0, 99) == 0, $urandom_range(0, 63) == 0,
                      $urandom_range(0, 499) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ber_phase_checker.md
Name: ber_phase_checker

Overview:
Parametrised bit-error-rate checker for one demodulated channel (I or Q) of the PRBS test link. It compares received bits against a locally generated reference PRBS. It first searches a configurable delay range for the best alignment phase, then locks and counts bits and errors. Unlike the previous counter, it counts only on valid samples, exits the search early on a perfect window, drops lock on excessive errors, and exposes its counters and phase.

Parameters:
DEPTH, 1024, number of candidate delays (taps 0..DEPTH-1); power of two, >=4
WIN, 511, valid bits evaluated per candidate and per lock-monitor window
LOCK_THR, 0, max window errors accepted to enter LOCKED after a full sweep
LOSS_THR, 64, window errors above which LOCKED falls back to SEARCH
CNT_W, 64, width of the bit and error accumulators

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  block enable; low freezes all state
i_valid  in  1  qualifies i_rx/i_ref for this cycle
i_rx  in  1  received (sliced filter output) bit
i_ref  in  1  local reference PRBS bit
i_clear  in  1  one-cycle pulse: zero o_bit_cnt/o_err_cnt
o_locked  out  1  high in LOCKED state
o_phase  out  $clog2(DEPTH)  selected delay tap
o_min_err  out  $clog2(WIN+1)  best window error count from the last sweep
o_search_fail  out  1  one-cycle pulse: sweep ended with min error > LOCK_THR
o_bit_cnt  out  CNT_W  valid bits counted while locked (saturating)
o_err_cnt  out  CNT_W  mismatches counted while locked (saturating)

Behaviour:
- Reset: state=SEARCH; all outputs 0 except o_min_err = all-ones. Delay line, tap pointer, window counters and best-tap registers are cleared.
- Delay line: the tap(p) value seen by a comparison is i_ref delayed by p valid samples, so tap(0)=i_ref in the same cycle. It is implemented as a (DEPTH-1)-bit shift register advancing only when i_valid && i_enable.
- Mismatch: i_rx ^ tap(sel). sel = search pointer in SEARCH, o_phase in LOCKED. Evaluated only when i_valid && i_enable.
- Window counter wcnt (0..WIN-1) and window error counter werr.
  - Both advance on valid samples only.
  - On the valid sample where wcnt==WIN-1, the window closes, including that sample's mismatch. wcnt and werr then return to 0 on the next cycle.
- SEARCH, at each window close, with e = closing error count:
  - If e < best: best=e and best_tap=ptr. Ties keep the lower tap.
  - If e==0: lock immediately. o_phase=ptr, o_min_err=0, go to LOCKED next cycle.
  - Else if ptr==DEPTH-1: o_min_err=best.
    - If best<=LOCK_THR: o_phase=best_tap, go to LOCKED.
    - Otherwise: pulse o_search_fail, ptr=0, best=all-ones, and search again.
  - Else ptr increments.
- LOCKED:
  - Each valid sample adds 1 to o_bit_cnt and the mismatch to o_err_cnt. Both saturate at 2^CNT_W-1.
  - Window monitor: if window errors > LOSS_THR at close, go to SEARCH with ptr=0 and best=all-ones. o_bit_cnt/o_err_cnt hold their values; o_phase holds until the next lock.
- SEARCH→LOCKED transition: the window counter restarts at 0. The sample that closed the search window is not counted.
- i_clear:
  - Zeroes o_bit_cnt/o_err_cnt next cycle in any state.
  - If it coincides with a count update, clear wins.
  - It does not affect state, phase or windows.
- i_enable low: no state changes at all. The delay line does not shift. A valid sample presented then is dropped.
- Reset mid-operation: returns to the reset state within one cycle, whatever the current state.
- Latency: outputs are registered; a count/state update is visible the cycle after the qualifying valid sample.

Decomposition:
- Package ber_pkg:
  - state enum {SEARCH, LOCKED}
  - helper function for the pointer width clog2(DEPTH)
  - default threshold constants
- Sub-module ber_delay_line (DEPTH):
  - shift register plus tap mux
  - ports: clock, i_reset, i_shift, i_bit, i_sel, o_tap
- FSM, window counters and accumulators live in ber_phase_checker.

Test Plan:
(Use DEPTH=16, WIN=31, LOCK_THR=0, LOSS_THR=3, CNT_W=16 unless stated.)
1. PRBS7, i_rx = i_ref delayed 5 valid samples, i_valid always 1 -> taps 0..4 fail, tap 5 closes with 0 errors. Expect o_locked=1 after exactly 6*31 valid samples + 1 cycle, o_phase=5, o_min_err=0.
2. Same as 1 with i_valid toggling 1/0 -> identical o_phase=5. Lock occurs after 372 cycles; no counting on invalid cycles.
3. Delay 9 plus one forced error per window, LOCK_THR=1 -> full sweep. Expect o_phase=9, o_min_err=1, lock after 16 windows. With LOCK_THR=0 -> o_search_fail pulses once per 16*31 valid samples and never locks.
4. Locked at phase 5, then invert i_rx for 10 consecutive valid bits inside one window -> errors 10>3. Expect return to SEARCH at window close; o_err_cnt=10 held; relock at phase 5.
5. Locked, 1000 valid error-free bits, then i_clear with a simultaneous valid error -> o_bit_cnt=0, o_err_cnt=0 next cycle.
6. CNT_W=4, locked, inject 20 errors -> o_err_cnt saturates at 15. Assert i_reset mid-search -> next cycle o_locked=0, o_phase=0, o_min_err=all-ones.
